// File: rtl/instr_fetch_decode.sv
// instr_fetch_decode
//   Fetch/decode front end. Holds the PC, issues one word fetch at a time to
//   instruction memory over a level req/ack handshake, latches the returned word
//   and presents it with its one-hot opcode class to the downstream controller.
//   Downstream can hold the current instruction (stall) or restart fetch at a new
//   target (redirect, which takes priority over everything except rst).
// Ports
//   clk, rst             rising-edge clock, synchronous active-high reset
//   imem_req/imem_addr   fetch request (level) and word address (= pc)
//   imem_ack/imem_rdata  memory response, honoured only while imem_req=1
//   stall                hold the presented instruction
//   redirect/redirect_pc restart fetch at redirect_pc (bits [1:0] forced to 0)
//   instr_valid/instr/pc presented instruction and its address
//   r_type..jalr         opcode class flags, one-hot, all 0 unless instr_valid
//   illegal              instr_valid=1 with an unrecognised opcode
module instr_fetch_decode #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  input  logic            stall,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            instr_valid,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] pc,
  output logic            r_type,
  output logic            i_type,
  output logic            load,
  output logic            store,
  output logic            branch,
  output logic            jal,
  output logic            jalr,
  output logic            illegal
);

  typedef enum logic [0:0] {StReq, StValid} state_e;

  state_e          state_q;
  logic [XLEN-1:0] pc_q;
  logic [31:0]     instr_q;
  logic            valid_q;
  // {illegal, jalr, jal, branch, store, load, i_type, r_type}
  logic [7:0]      cls_q;

  function automatic logic [7:0] decode(input logic [31:0] w);
    logic [7:0] d;
    case (w[6:0])
      7'b0110011: d = 8'h01;
      7'b0010011: d = 8'h02;
      7'b0000011: d = 8'h04;
      7'b0100011: d = 8'h08;
      7'b1100011: d = 8'h10;
      7'b1101111: d = 8'h20;
      7'b1100111: d = 8'h40;
      default:    d = 8'h80;
    endcase
    return d;
  endfunction

  // Class flags are decoded once at capture and registered with the instruction,
  // so they are cleared together with instr_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StReq;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      valid_q <= 1'b0;
      cls_q   <= '0;
    end else if (redirect) begin
      // Any same-cycle ack is dropped; the fetch restarts at the new target.
      state_q <= StReq;
      pc_q    <= redirect_pc & ~(XLEN'(3));
      valid_q <= 1'b0;
      cls_q   <= '0;
    end else begin
      case (state_q)
        StReq: begin
          if (imem_ack) begin
            instr_q <= imem_rdata;
            valid_q <= 1'b1;
            cls_q   <= decode(imem_rdata);
            state_q <= StValid;
          end
        end
        StValid: begin
          if (!stall) begin
            pc_q    <= pc_q + XLEN'(4);
            valid_q <= 1'b0;
            cls_q   <= '0;
            state_q <= StReq;
          end
        end
        default: state_q <= StReq;
      endcase
    end
  end

  assign imem_req    = (state_q == StReq);
  assign imem_addr   = pc_q;
  assign instr_valid = valid_q;
  assign instr       = instr_q;
  assign pc          = pc_q;
  assign r_type      = cls_q[0];
  assign i_type      = cls_q[1];
  assign load        = cls_q[2];
  assign store       = cls_q[3];
  assign branch      = cls_q[4];
  assign jal         = cls_q[5];
  assign jalr        = cls_q[6];
  assign illegal     = cls_q[7];

endmodule

// File: tb/tb_instr_fetch_decode.sv
module tb_instr_fetch_decode;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req, imem_ack, stall, redirect, instr_valid;
  logic [31:0] imem_addr, imem_rdata, redirect_pc, instr, pc;
  logic        r_type, i_type, load, store, branch, jal, jalr, illegal;

  // Second instance exercising PC wrap from RESET_PC = 0xFFFF_FFFC.
  logic        w_req, w_ack, w_valid;
  logic [31:0] w_addr, w_rdata, w_instr, w_pc;
  logic        w_r, w_i, w_ld, w_st, w_br, w_jal, w_jalr, w_ill;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  instr_fetch_decode #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .stall(stall),
    .redirect(redirect), .redirect_pc(redirect_pc), .instr_valid(instr_valid),
    .instr(instr), .pc(pc), .r_type(r_type), .i_type(i_type), .load(load),
    .store(store), .branch(branch), .jal(jal), .jalr(jalr), .illegal(illegal)
  );

  instr_fetch_decode #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .rst(rst), .imem_req(w_req), .imem_addr(w_addr),
    .imem_ack(w_ack), .imem_rdata(w_rdata), .stall(1'b0),
    .redirect(1'b0), .redirect_pc(32'h0), .instr_valid(w_valid),
    .instr(w_instr), .pc(w_pc), .r_type(w_r), .i_type(w_i), .load(w_ld),
    .store(w_st), .branch(w_br), .jal(w_jal), .jalr(w_jalr), .illegal(w_ill)
  );

  function automatic logic [7:0] flags();
    return {illegal, jalr, jal, branch, store, load, i_type, r_type};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Inputs are driven and outputs sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req();
    for (int i = 0; i < 10 && !imem_req; i++) step();
    chk("wait_req", {31'b0, imem_req}, 32'h1);
  endtask

  typedef struct {
    logic [31:0] word;
    logic [7:0]  exp;  // {illegal, jalr, jal, branch, store, load, i_type, r_type}
  } vec_t;

  vec_t vecs[10];

  initial begin
    vecs[0] = '{32'h0020_81B3, 8'h01};
    vecs[1] = '{32'h0050_0093, 8'h02};
    vecs[2] = '{32'h0000_0003, 8'h04};
    vecs[3] = '{32'h0000_0023, 8'h08};
    vecs[4] = '{32'h0000_0063, 8'h10};
    vecs[5] = '{32'h0000_006F, 8'h20};
    vecs[6] = '{32'h0000_0067, 8'h40};
    vecs[7] = '{32'h0000_0000, 8'h80};
    vecs[8] = '{32'h0000_007F, 8'h80};
    vecs[9] = '{32'h0000_0032, 8'h80};

    rst = 1'b1; imem_ack = 1'b0; imem_rdata = '0; stall = 1'b0;
    redirect = 1'b0; redirect_pc = '0; w_ack = 1'b0; w_rdata = '0;
    step(); step();
    rst = 1'b0;

    // Reset state.
    chk("rst_req", {31'b0, imem_req}, 32'h1);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", {31'b0, instr_valid}, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_flags", {24'b0, flags()}, 32'h0);
    chk("rst_w_addr", w_addr, 32'hFFFF_FFFC);

    // 1: zero-wait fetch at 0.
    imem_ack = 1'b1; imem_rdata = 32'h0050_0093;
    step();
    imem_ack = 1'b0;
    chk("t1_valid", {31'b0, instr_valid}, 32'h1);
    chk("t1_flags", {24'b0, flags()}, 32'h02);
    chk("t1_pc", pc, 32'h0);
    chk("t1_req_low", {31'b0, imem_req}, 32'h0);
    step();
    chk("t1_req", {31'b0, imem_req}, 32'h1);
    chk("t1_addr", imem_addr, 32'h4);
    chk("t1_valid_low", {31'b0, instr_valid}, 32'h0);

    // 2: ack delayed 3 clocks.
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t2_req_held", {31'b0, imem_req}, 32'h1);
      chk("t2_addr_held", imem_addr, 32'h4);
    end
    imem_ack = 1'b1; imem_rdata = 32'h0020_81B3;
    step();
    imem_ack = 1'b0;
    chk("t2_valid", {31'b0, instr_valid}, 32'h1);
    chk("t2_instr", instr, 32'h0020_81B3);
    chk("t2_pc", pc, 32'h4);

    // 3: stall holds VALID for 4 clocks.
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t3_valid", {31'b0, instr_valid}, 32'h1);
      chk("t3_instr", instr, 32'h0020_81B3);
      chk("t3_pc", pc, 32'h4);
      chk("t3_flags", {24'b0, flags()}, 32'h01);
      chk("t3_req", {31'b0, imem_req}, 32'h0);
    end
    stall = 1'b0;
    step();
    chk("t3_req_after", {31'b0, imem_req}, 32'h1);
    chk("t3_addr_after", imem_addr, 32'h8);

    // 4: redirect in the same cycle as ack.
    imem_ack = 1'b1; imem_rdata = 32'h0000_0033;
    redirect = 1'b1; redirect_pc = 32'h0000_0103;
    step();
    imem_ack = 1'b0; redirect = 1'b0;
    chk("t4_valid", {31'b0, instr_valid}, 32'h0);
    chk("t4_req", {31'b0, imem_req}, 32'h1);
    chk("t4_addr", imem_addr, 32'h100);
    // Redirect overrides stall while VALID.
    imem_ack = 1'b1; imem_rdata = 32'h0000_0013;
    step();
    imem_ack = 1'b0;
    chk("t4b_pc", pc, 32'h100);
    stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0202;
    step();
    stall = 1'b0; redirect = 1'b0;
    chk("t4b_valid", {31'b0, instr_valid}, 32'h0);
    chk("t4b_addr", imem_addr, 32'h200);
    chk("t4b_flags", {24'b0, flags()}, 32'h0);

    // 5: opcode decode table.
    foreach (vecs[k]) begin
      wait_req();
      imem_ack = 1'b1; imem_rdata = vecs[k].word;
      step();
      imem_ack = 1'b0;
      chk($sformatf("t5_flags[%0d]", k), {24'b0, flags()}, {24'b0, vecs[k].exp});
      chk($sformatf("t5_instr[%0d]", k), instr, vecs[k].word);
      step();
      chk($sformatf("t5_clear[%0d]", k), {24'b0, flags()}, 32'h0);
    end

    // 6: PC wraps from 0xFFFF_FFFC to 0.
    w_ack = 1'b1; w_rdata = 32'h0050_0093;
    step();
    w_ack = 1'b0;
    chk("t6_valid", {31'b0, w_valid}, 32'h1);
    chk("t6_pc", w_pc, 32'hFFFF_FFFC);
    chk("t6_itype", {31'b0, w_i}, 32'h1);
    step();
    chk("t6_req", {31'b0, w_req}, 32'h1);
    chk("t6_addr_wrap", w_addr, 32'h0);

    // Reset mid-transaction drops the pending ack.
    wait_req();
    imem_ack = 1'b1; imem_rdata = 32'h0000_0013; rst = 1'b1;
    step();
    imem_ack = 1'b0; rst = 1'b0;
    chk("rst_mid_valid", {31'b0, instr_valid}, 32'h0);
    chk("rst_mid_addr", imem_addr, 32'h0);
    chk("rst_mid_instr", instr, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
